complete_arbiter: RTL and testbench

- Shares the CDB_W complete-stage (CDB) ports among NUM_FU functional units (ALU, fu_mult instances, branch, load) that each raise want_to_complete.
- Each cycle, grants up to CDB_W FUs. Drives complete_stall back to each losing FU, which then holds its result.
- Fairness: a rotating round-robin pointer, plus per-FU starvation counters that force priority.
- Sits between the FU bank and the CDB/ROB-complete logic. Outputs the select indices used by the CDB data muxes.

---
 rtl/complete_arbiter.sv | 148 ++++++++++++++
 tb/tb_complete_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
// -----------------------------------------------------------------------------
// complete_arbiter
//   Shares CDB_W complete-stage (CDB) ports among NUM_FU functional units.
//   Every cycle up to CDB_W requesters are granted. Starved FUs go first in
//   ascending index order. The remaining FUs follow in round-robin order
//   starting at rr_ptr. Losing requesters get complete_stall and hold their
//   result.
//
// Ports
//   clock            : system clock, state updates on posedge
//   reset            : asynchronous active-low reset
//   want_to_complete : per-FU "result valid" request
//   cdb_block        : complete stage accepts nothing this cycle
//   complete_stall   : per-FU "hold your result" (want & ~grant)
//   grant            : per-FU grant, popcount <= CDB_W
//   cdb_valid        : CDB port k carries a granted FU
//   cdb_sel          : FU index routed to CDB port k (SEL_W bits per port)
//   starved          : per-FU stall counter >= STARVE_LIMIT (debug)
// -----------------------------------------------------------------------------
module complete_arbiter #(
  parameter  int NUM_FU       = 4,
  parameter  int CDB_W        = 2,
  parameter  int STARVE_LIMIT = 6,
  localparam int SEL_W        = $clog2(NUM_FU)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        want_to_complete,
  input  logic                     cdb_block,
  output logic [NUM_FU-1:0]        complete_stall,
  output logic [NUM_FU-1:0]        grant,
  output logic [CDB_W-1:0]         cdb_valid,
  output logic [CDB_W*SEL_W-1:0]   cdb_sel,
  output logic [NUM_FU-1:0]        starved
);

  logic [SEL_W-1:0]       rr_ptr_q;
  logic [SEL_W-1:0]       rr_ptr_d;
  logic [3:0]             stall_cnt_q [NUM_FU];
  logic [3:0]             stall_cnt_d [NUM_FU];

  logic [NUM_FU-1:0]      starved_s;
  logic [NUM_FU-1:0]      grant_s;
  logic [CDB_W-1:0]       cdb_valid_s;
  logic [CDB_W*SEL_W-1:0] cdb_sel_s;
  logic                   rr_won_s;
  logic [SEL_W-1:0]       last_rr_s;

  // Starvation flags straight from the registered counters.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      starved_s[i] = (stall_cnt_q[i] >= 4'(STARVE_LIMIT));
    end
  end

  // Winner selection: starved FUs first, then round-robin from rr_ptr.
  always_comb begin : arb_comb
    int               n_win;
    logic [SEL_W-1:0] idx;
    grant_s     = '0;
    cdb_valid_s = '0;
    cdb_sel_s   = '0;
    rr_won_s    = 1'b0;
    last_rr_s   = '0;
    n_win       = 0;
    idx         = '0;
    // Grants are suppressed while in reset so the outputs read as idle.
    if (reset && !cdb_block) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (want_to_complete[i] && starved_s[i] && (n_win < CDB_W)) begin
          grant_s[i] = 1'b1;
          for (int k = 0; k < CDB_W; k++) begin
            if (k == n_win) begin
              cdb_valid_s[k]                = 1'b1;
              cdb_sel_s[k*SEL_W +: SEL_W]   = SEL_W'(i);
            end else begin
              cdb_valid_s[k]                = cdb_valid_s[k];
            end
          end
          n_win = n_win + 1;
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
      for (int j = 0; j < NUM_FU; j++) begin
        idx = SEL_W'((int'(rr_ptr_q) + j) % NUM_FU);
        // Starved FUs were already considered above; skip them here.
        if (want_to_complete[idx] && !starved_s[idx] && (n_win < CDB_W)) begin
          grant_s[idx] = 1'b1;
          rr_won_s     = 1'b1;
          last_rr_s    = idx;
          for (int k = 0; k < CDB_W; k++) begin
            if (k == n_win) begin
              cdb_valid_s[k]                = 1'b1;
              cdb_sel_s[k*SEL_W +: SEL_W]   = idx;
            end else begin
              cdb_valid_s[k]                = cdb_valid_s[k];
            end
          end
          n_win = n_win + 1;
        end else begin
          grant_s[idx] = grant_s[idx];
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Next-state: pointer moves past the last round-robin winner; counters
  // saturate while stalled and clear otherwise.
  always_comb begin
    if (rr_won_s) begin
      rr_ptr_d = SEL_W'((int'(last_rr_s) + 1) % NUM_FU);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (want_to_complete[i] && !grant_s[i]) begin
        stall_cnt_d[i] = (stall_cnt_q[i] == 4'd15) ? 4'd15 : (stall_cnt_q[i] + 4'd1);
      end else begin
        stall_cnt_d[i] = 4'd0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        stall_cnt_q[i] <= 4'd0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_FU; i++) begin
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end

  assign grant          = grant_s;
  assign complete_stall = want_to_complete & ~grant_s;
  assign cdb_valid      = cdb_valid_s;
  assign cdb_sel        = cdb_sel_s;
  assign starved        = starved_s;

endmodule

// File: tb/tb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// tb_complete_arbiter
//   Directed-vector bench for complete_arbiter. Two instances share inputs:
//   u_w2 (NUM_FU=4, CDB_W=2) and u_w1 (NUM_FU=4, CDB_W=1). Inputs change on
//   the falling edge and outputs are sampled 2 time units later.
// -----------------------------------------------------------------------------
module tb_complete_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] want;
  logic       cdb_block;

  logic [3:0] stall_w2, grant_w2, starved_w2;
  logic [1:0] valid_w2;
  logic [3:0] sel_w2;

  logic [3:0] stall_w1, grant_w1, starved_w1;
  logic [0:0] valid_w1;
  logic [1:0] sel_w1;

  int n_vec = 0;
  int n_mis = 0;

  complete_arbiter #(.NUM_FU(4), .CDB_W(2), .STARVE_LIMIT(6)) u_w2 (
    .clock            (clock),
    .reset            (reset),
    .want_to_complete (want),
    .cdb_block        (cdb_block),
    .complete_stall   (stall_w2),
    .grant            (grant_w2),
    .cdb_valid        (valid_w2),
    .cdb_sel          (sel_w2),
    .starved          (starved_w2)
  );

  complete_arbiter #(.NUM_FU(4), .CDB_W(1), .STARVE_LIMIT(6)) u_w1 (
    .clock            (clock),
    .reset            (reset),
    .want_to_complete (want),
    .cdb_block        (cdb_block),
    .complete_stall   (stall_w1),
    .grant            (grant_w1),
    .cdb_valid        (valid_w1),
    .cdb_sel          (sel_w1),
    .starved          (starved_w1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] w, input logic b);
    @(negedge clock);
    want      = w;
    cdb_block = b;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    want      = 4'b0000;
    cdb_block = 1'b0;

    // Reset state, requests present during reset are all stalled.
    repeat (2) @(negedge clock);
    want = 4'b1111;
    #2;
    check_vec("rst_grant",   grant_w2,   4'b0000);
    check_vec("rst_stall",   stall_w2,   4'b1111);
    check_vec("rst_valid",   valid_w2,   2'b00);
    check_vec("rst_sel",     sel_w2,     4'b0000);
    check_vec("rst_starved", starved_w2, 4'b0000);
    want  = 4'b0000;
    reset = 1'b1;

    // All four request: FU0,FU1 win, then pointer at 2 gives FU2,FU3.
    drive(4'b1111, 1'b0);
    check_vec("a_grant", grant_w2, 4'b0011);
    check_vec("a_sel",   sel_w2,   4'b0100);
    check_vec("a_valid", valid_w2, 2'b11);
    check_vec("a_stall", stall_w2, 4'b1100);
    drive(4'b1111, 1'b0);
    check_vec("b_grant", grant_w2, 4'b1100);
    check_vec("b_sel",   sel_w2,   4'b1110);

    // Single requester uses port 0 only.
    drive(4'b0100, 1'b0);
    check_vec("c_grant", grant_w2, 4'b0100);
    check_vec("c_valid", valid_w2, 2'b01);
    check_vec("c_sel",   sel_w2,   4'b0010);
    check_vec("c_stall", stall_w2, 4'b0000);

    // Pointer now 3: FU3 alone wins, pointer wraps to 0.
    drive(4'b1000, 1'b0);
    check_vec("d_grant", grant_w2, 4'b1000);
    check_vec("d_sel",   sel_w2,   4'b0011);

    // Blocked CDB for 8 cycles: FU3 stalls and becomes starved.
    for (int n = 1; n <= 8; n++) begin
      drive(4'b1000, 1'b1);
      check_vec("blk_grant",   grant_w2,   4'b0000);
      check_vec("blk_stall",   stall_w2,   4'b1000);
      check_vec("blk_valid",   valid_w2,   2'b00);
      check_vec("blk_starved", starved_w2, (n >= 7) ? 4'b1000 : 4'b0000);
    end

    // Starved FU3 outranks FU0 at the pointer; FU0 takes port 1.
    drive(4'b1111, 1'b0);
    check_vec("e_grant", grant_w2, 4'b1001);
    check_vec("e_sel",   sel_w2,   4'b0011);
    check_vec("e_valid", valid_w2, 2'b11);
    check_vec("e_stall", stall_w2, 4'b0110);
    drive(4'b1111, 1'b0);
    check_vec("f_grant",   grant_w2,   4'b0110);
    check_vec("f_sel",     sel_w2,     4'b1001);
    check_vec("f_starved", starved_w2, 4'b0000);

    // Single-port instance: grants rotate 0,1,2,3 from a fresh reset.
    @(negedge clock);
    want  = 4'b0000;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(4'b1111, 1'b0);
      check_vec("w1_grant",   grant_w1,   32'(4'b0001 << n));
      check_vec("w1_sel",     sel_w1,     n);
      check_vec("w1_valid",   valid_w1,   1'b1);
      check_vec("w1_starved", starved_w1, 4'b0000);
    end

    // FU1 stalls behind a blocked CDB, then reset hits mid-stall.
    for (int n = 0; n < 7; n++) begin
      drive(4'b0010, 1'b1);
    end
    drive(4'b0010, 1'b1);
    check_vec("g_starved", starved_w2, 4'b0010);
    #1;
    reset = 1'b0;
    #1;
    check_vec("g_rst_starved", starved_w2, 4'b0000);
    check_vec("g_rst_grant",   grant_w2,   4'b0000);
    check_vec("g_rst_stall",   stall_w2,   4'b0010);
    @(negedge clock);
    reset     = 1'b1;
    want      = 4'b0010;
    cdb_block = 1'b0;
    #2;
    check_vec("h_grant",    grant_w2, 4'b0010);
    check_vec("h_sel",      sel_w2,   4'b0001);
    check_vec("h_valid",    valid_w2, 2'b01);
    check_vec("h_w1_grant", grant_w1, 4'b0010);
    check_vec("h_w1_sel",   sel_w1,   2'b01);

    // FU2 stalled 20 cycles: counter saturates, starved never drops.
    for (int n = 1; n <= 20; n++) begin
      drive(4'b0100, 1'b1);
      check_vec("sat_starved", starved_w2, (n >= 7) ? 4'b0100 : 4'b0000);
    end
    drive(4'b0100, 1'b0);
    check_vec("sat_cnt",   u_w2.stall_cnt_q[2], 4'd15);
    check_vec("sat_grant", grant_w2,            4'b0100);
    check_vec("sat_stall", stall_w2,            4'b0000);
    drive(4'b0000, 1'b0);
    check_vec("clr_cnt",     u_w2.stall_cnt_q[2], 4'd0);
    check_vec("clr_starved", starved_w2,          4'b0000);
    check_vec("idle_valid",  valid_w2,            2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
